// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT widths, packed complex sample type and bit-reverse helper
package fft_pkg;

  localparam int FFT_WIDTH  = 16;
  localparam int FFT_N_LOG2 = 9;

  // One FFT result word as stored in the result RAM: {re, im}, Q1.15 each.
  typedef struct packed {
    logic signed [FFT_WIDTH-1:0] re;
    logic signed [FFT_WIDTH-1:0] im;
  } fft_cplx_t;

  // Reverse the low 'bits' bits of value; bits must be a constant when synthesised.
  function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int bits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < bits; i++) begin
      r[bits-1-i] = value[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/mag_fifo.sv
// rtl/mag_fifo.sv - 4-entry show-ahead synchronous FIFO for magnitude beats
module mag_fifo #(
  parameter int DW = 40
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic [2:0]    count
);

  logic [DW-1:0] mem [4];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic          push;
  logic          pop;

  // The reader's credit scheme guarantees space, so every write is taken.
  assign push     = wr_valid;
  assign pop      = rd_valid && rd_ready;
  assign rd_valid = (count != 3'd0);
  assign rd_data  = mem[rd_ptr];

  // Pointer, occupancy and storage update; storage cleared so idle outputs read zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fft_mag_reader.sv
// rtl/fft_mag_reader.sv - unloads half an FFT frame as re^2+im^2 beats; FFT_MAG_BITREV_EN selects bit-reversed RAM addressing
module fft_mag_reader
  import fft_pkg::*;
#(
  parameter int WIDTH  = FFT_WIDTH,
  parameter int N_LOG2 = FFT_N_LOG2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [N_LOG2-1:0]    rd_addr,
  input  logic [2*WIDTH-1:0]   rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_LOG2-2:0]    out_bin,
  output logic [2*WIDTH-1:0]   out_mag,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam int              BW       = N_LOG2 - 1;
  localparam int              FW       = BW + 2 * WIDTH;
  localparam logic [BW-1:0]   LAST_BIN = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]                state;
  logic [BW-1:0]             cnt;
  logic                      v0, v1, v2;
  logic [BW-1:0]             b0, b1, b2;
  logic signed [WIDTH-1:0]   re, im;
  logic signed [2*WIDTH-1:0] sq_re, sq_im;
  logic [2*WIDTH-1:0]        mag_sum;
  logic [2:0]                fifo_count;
  logic [3:0]                occ;
  logic                      pop;
  logic                      issue;

  // Only the lower half of the spectrum is read; optionally in bit-reversed RAM order.
  function automatic logic [N_LOG2-1:0] bin_addr(input logic [BW-1:0] bin);
`ifdef FFT_MAG_BITREV_EN
    logic [31:0] r;
    r = bit_reverse(32'(bin), N_LOG2);
    return r[N_LOG2-1:0];
`else
    return {1'b0, bin};
`endif
  endfunction

  assign re      = rd_data[2*WIDTH-1:WIDTH];
  assign im      = rd_data[WIDTH-1:0];
  assign mag_sum = $unsigned(sq_re) + $unsigned(sq_im);
  assign pop     = out_valid && out_ready;
  assign busy    = (state != S_IDLE);

  // Entries that will be held after this edge must never exceed the FIFO depth;
  // counting this cycle's pop keeps one beat per cycle flowing with out_ready high.
  assign occ   = {1'b0, fifo_count} + {3'b0, v0} + {3'b0, v1} + {3'b0, v2} - {3'b0, pop};
  assign issue = (state == S_READ) && (occ < 4'd4);

  // Control FSM and address issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rd_addr <= '0;
      v0      <= 1'b0;
      b0      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      v0   <= issue;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_READ;
            cnt   <= '0;
          end
        end
        S_READ: begin
          if (issue) begin
            rd_addr <= bin_addr(cnt);
            b0      <= cnt;
            if (cnt == LAST_BIN) begin
              state <= S_DRAIN;
            end else begin
              cnt <= cnt + BW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (pop && out_last) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM-latency and squaring stages; squares are full-precision signed products.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      b1    <= '0;
      b2    <= '0;
      sq_re <= '0;
      sq_im <= '0;
    end else begin
      v1    <= v0;
      b1    <= b0;
      v2    <= v1;
      b2    <= b1;
      sq_re <= (2*WIDTH)'(re) * (2*WIDTH)'(re);
      sq_im <= (2*WIDTH)'(im) * (2*WIDTH)'(im);
    end
  end

  mag_fifo #(
    .DW (FW)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (v2),
    .wr_data  ({b2, mag_sum}),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  ({out_bin, out_mag}),
    .count    (fifo_count)
  );

  assign out_last = out_valid && (out_bin == LAST_BIN);

endmodule

// File: tb/tb_fft_mag_reader.sv
// tb/tb_fft_mag_reader.sv - self-checking bench for fft_mag_reader with a RAM and magnitude reference model
module tb_fft_mag_reader;
  import fft_pkg::*;

  localparam int NBINS  = 256;
  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  rd_addr;
  logic [31:0] rd_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_bin;
  logic [31:0] out_mag;
  logic        out_last;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  fft_cplx_t ram [512];

  int          q_bin [$];
  logic [31:0] q_mag [$];
  bit          q_last [$];
  int first_valid, done_cnt, done_at, last_acc, unstable, max_out, pauses;
  bit timed_out;
  logic rst_valid, rst_busy;
  int addr_at [8];

  fft_mag_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_mag   (out_mag),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Result RAM with one cycle of read latency.
  always @(posedge clk) rd_data <= ram[rd_addr];

  function automatic int addr_of(input int k);
`ifdef FFT_MAG_BITREV_EN
    int r = 0;
    for (int i = 0; i < 9; i++) if (((k >> i) & 1) != 0) r = r | (1 << (8 - i));
    return r;
`else
    return k;
`endif
  endfunction

  function automatic logic [31:0] exp_mag(input int k);
    fft_cplx_t s = ram[addr_of(k)];
    longint r = s.re;
    longint i = s.im;
    return 32'(r * r + i * i);
  endfunction

  // Runs one frame and records what the DUT did; the test tasks judge it.
  task automatic collect(input bit stall, input int restart_at, input int reset_at);
    logic pv = 0, pr = 0, pl = 0;
    logic [7:0] pb = 0;
    logic [31:0] pm = 0;
    logic [8:0] pa = 0;
    int issued = -1, acc = 0, tail = -1;
    bit restarted = 0;
    q_bin.delete(); q_mag.delete(); q_last.delete();
    first_valid = -1; done_cnt = 0; done_at = -1; last_acc = -1;
    unstable = 0; max_out = 0; pauses = 0; timed_out = 1;
    rst_valid = 1'b1; rst_busy = 1'b1;
    for (int i = 0; i < 8; i++) addr_at[i] = -1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      if (c < 8) addr_at[c] = int'(rd_addr);
      if (out_valid && first_valid < 0) first_valid = c;
      if (done) begin
        done_cnt++;
        done_at = c;
        if (tail < 0) tail = c + 3;
      end
      if (pv && !pr && (!out_valid || out_bin !== pb || out_mag !== pm || out_last !== pl)) unstable++;
      if (issued < NBINS - 1 && int'(rd_addr) == addr_of(issued + 1)) issued++;
      else if (c > 1 && busy && issued < NBINS - 1 && rd_addr == pa) pauses++;
      if (issued + 1 - acc > max_out) max_out = issued + 1 - acc;
      if (c == tail) begin
        timed_out = 0;
        break;
      end
      start = 1'b0;
      out_ready = stall ? (c % 3 == 0) : 1'b1;
      pv = out_valid; pr = out_ready; pb = out_bin; pm = out_mag; pl = out_last; pa = rd_addr;
      if (out_valid && out_ready) begin
        q_bin.push_back(int'(out_bin));
        q_mag.push_back(out_mag);
        q_last.push_back(out_last);
        acc++;
        if (out_last) last_acc = c;
      end
      if (restart_at >= 0 && acc == restart_at && !restarted) begin
        start = 1'b1;
        restarted = 1;
      end
      if (reset_at >= 0 && acc == reset_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        rst_valid = out_valid;
        rst_busy = busy;
        for (int j = 0; j < 6; j++) begin
          if (done) done_cnt++;
          @(posedge clk); #1;
        end
        timed_out = 0;
        return;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (rd_addr !== 9'd0) begin failures++; $display("FAIL reset_rd_addr got=%0d want=0", rd_addr); end
    checks++; if (out_bin !== 8'd0) begin failures++; $display("FAIL reset_out_bin got=%0d want=0", out_bin); end
    checks++; if (out_mag !== 32'd0) begin failures++; $display("FAIL reset_out_mag got=%h want=0", out_mag); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ramp();
    int errs = 0;
    int a1, a2;
`ifdef FFT_MAG_BITREV_EN
    a1 = 256; a2 = 128;
`else
    a1 = 1; a2 = 2;
`endif
    for (int k = 0; k < 512; k++) ram[k] = '0;
    for (int k = 0; k < NBINS; k++) ram[addr_of(k)] = {16'(k), 16'h0000};
    collect(1'b0, -1, -1);
    checks++; if (timed_out) begin failures++; $display("FAIL ramp_timeout got=%0d beats want=256", q_bin.size()); end
    checks++; if (first_valid != 4) begin failures++; $display("FAIL ramp_first_valid got=%0d want=4", first_valid); end
    checks++; if (q_bin.size() != NBINS) begin failures++; $display("FAIL ramp_beats got=%0d want=256", q_bin.size()); end
    foreach (q_bin[i]) begin
      if (q_bin[i] != i || q_mag[i] !== 32'(i * i) || q_last[i] != (i == NBINS - 1)) begin
        if (errs == 0) $display("FAIL ramp_beat%0d got bin=%0d mag=%h last=%b want bin=%0d mag=%h", i, q_bin[i], q_mag[i], q_last[i], i, 32'(i * i));
        errs++;
      end
    end
    checks++; if (errs != 0) failures++;
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL ramp_done_count got=%0d want=1", done_cnt); end
    checks++; if (done_at != last_acc + 1) begin failures++; $display("FAIL ramp_done_timing got=%0d want=%0d", done_at, last_acc + 1); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ramp_busy_after got=%b want=0", busy); end
    checks++; if (pauses != 0) begin failures++; $display("FAIL ramp_addr_bubbles got=%0d want=0", pauses); end
    checks++; if (addr_at[2] != a1) begin failures++; $display("FAIL ramp_addr_bin1 got=%0d want=%0d", addr_at[2], a1); end
    checks++; if (addr_at[3] != a2) begin failures++; $display("FAIL ramp_addr_bin2 got=%0d want=%0d", addr_at[3], a2); end
  endtask

  task automatic test_backpressure();
    int errs = 0;
    for (int k = 0; k < 512; k++) ram[k] = $urandom;
    ram[addr_of(3)] = 32'h8000_8000;
    collect(1'b1, -1, -1);
    checks++; if (timed_out) begin failures++; $display("FAIL bp_timeout got=%0d beats want=256", q_bin.size()); end
    checks++; if (q_bin.size() != NBINS) begin failures++; $display("FAIL bp_beats got=%0d want=256", q_bin.size()); end
    foreach (q_bin[i]) begin
      if (q_bin[i] != i || q_mag[i] !== exp_mag(i) || q_last[i] != (i == NBINS - 1)) begin
        if (errs == 0) $display("FAIL bp_beat%0d got bin=%0d mag=%h want bin=%0d mag=%h", i, q_bin[i], q_mag[i], i, exp_mag(i));
        errs++;
      end
    end
    checks++; if (errs != 0) failures++;
    if (q_mag.size() > 3) begin
      checks++; if (q_mag[3] !== 32'h8000_0000) begin failures++; $display("FAIL bp_full_scale got=%h want=80000000", q_mag[3]); end
    end
    checks++; if (unstable != 0) begin failures++; $display("FAIL bp_stall_stable got=%0d changes want=0", unstable); end
    checks++; if (max_out > 4) begin failures++; $display("FAIL bp_outstanding got=%0d want<=4", max_out); end
    checks++; if (pauses == 0) begin failures++; $display("FAIL bp_addr_pause got=%0d want>0", pauses); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL bp_done_count got=%0d want=1", done_cnt); end
  endtask

  task automatic test_start_ignored();
    int errs = 0;
    for (int k = 0; k < 512; k++) ram[k] = $urandom;
    collect(1'b0, 100, -1);
    checks++; if (q_bin.size() != NBINS) begin failures++; $display("FAIL restart_beats got=%0d want=256", q_bin.size()); end
    foreach (q_bin[i]) begin
      if (q_bin[i] != i || q_mag[i] !== exp_mag(i)) begin
        if (errs == 0) $display("FAIL restart_beat%0d got bin=%0d mag=%h want bin=%0d mag=%h", i, q_bin[i], q_mag[i], i, exp_mag(i));
        errs++;
      end
    end
    checks++; if (errs != 0) failures++;
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL restart_done_count got=%0d want=1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int errs = 0;
    for (int k = 0; k < 512; k++) ram[k] = $urandom;
    collect(1'b0, -1, 50);
    checks++; if (rst_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid got=%b want=0", rst_valid); end
    checks++; if (rst_busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b want=0", rst_busy); end
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL midreset_done got=%0d want=0", done_cnt); end
    collect(1'b0, -1, -1);
    checks++; if (q_bin.size() != NBINS) begin failures++; $display("FAIL rerun_beats got=%0d want=256", q_bin.size()); end
    checks++; if (first_valid != 4) begin failures++; $display("FAIL rerun_first_valid got=%0d want=4", first_valid); end
    foreach (q_bin[i]) begin
      if (q_bin[i] != i || q_mag[i] !== exp_mag(i)) begin
        if (errs == 0) $display("FAIL rerun_beat%0d got bin=%0d mag=%h want bin=%0d mag=%h", i, q_bin[i], q_mag[i], i, exp_mag(i));
        errs++;
      end
    end
    checks++; if (errs != 0) failures++;
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL rerun_done_count got=%0d want=1", done_cnt); end
  endtask

  initial begin
    for (int k = 0; k < 512; k++) ram[k] = '0;
    test_reset();
    test_ramp();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_mag_reader.md
FFT_MAG_READER -- requirements
Module: fft_mag_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 16: bit width of each real/imag component (Q1.15).
REQ-002 SHALL have parameter N_LOG2, default 9: log2 of FFT length (512 points).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to unload a completed FFT frame.
REQ-006 SHALL have port rd_addr, output, N_LOG2: result RAM read address.
REQ-007 SHALL have port rd_data, input, 2*WIDTH: RAM read data {re, im}, valid one cycle after rd_addr.
REQ-008 SHALL have port out_valid, output, 1: output beat available.
REQ-009 SHALL have port out_ready, input, 1: downstream accepts beat when high with out_valid.
REQ-010 SHALL have port out_bin, output, N_LOG2-1: bin index of the current beat.
REQ-011 SHALL have port out_mag, output, 2*WIDTH: unsigned re^2+im^2 of the current beat.
REQ-012 SHALL have port out_last, output, 1: high on the beat for bin 2^(N_LOG2-1)-1.
REQ-013 SHALL have port busy, output, 1: high from accepted start until the last beat is accepted.
REQ-014 SHALL have port done, output, 1: one-cycle pulse the cycle after the last beat is accepted.

Function
REQ-015 SHALL implement FSM IDLE -> READ (start in IDLE) -> DRAIN (last address issued) -> IDLE (last beat accepted).
REQ-016 SHALL ignore start while not in IDLE.
REQ-017 SHALL read bins 0 .. 2^(N_LOG2-1)-1 only (256 bins by default), one address per cycle.
REQ-018 SHALL form the pipeline address -> RAM data (+1) -> registered squares (+2) -> registered sum into output FIFO (+3).
REQ-019 SHALL assert first out_valid exactly 4 cycles after the edge that samples start, with out_ready held high.
REQ-020 SHALL sustain one beat per cycle while out_ready is high.
REQ-021 SHALL compute out_mag = re*re + im*im at full precision, signed operands, unsigned 2*WIDTH result, no truncation or saturation ((-32768)^2*2 = 2^31 fits).
REQ-022 SHALL buffer results in a 4-entry FIFO and issue a new address only when (FIFO occupancy + in-flight beats) < 4; no beat is ever dropped.
REQ-023 SHALL hold out_valid, out_bin, out_mag and out_last stable while out_valid is high and out_ready is low.
REQ-024 SHALL keep rd_addr at its last issued value when stalled or idle.

Reset
REQ-025 SHALL, on reset, drive out_valid=0, out_last=0, busy=0, done=0, rd_addr=0, out_bin=0, out_mag=0.
REQ-026 SHALL, on reset mid-frame, return to IDLE, flush FIFO and pipeline, and not pulse done.

Configuration
REQ-027 SHALL, with FFT_MAG_BITREV_EN defined, drive rd_addr = bit-reverse(bin) over N_LOG2 bits; out_bin still natural order.
REQ-028 SHALL, without FFT_MAG_BITREV_EN, drive rd_addr = bin (natural order).

Structure
REQ-029 SHALL take WIDTH/N_LOG2 defaults and a packed complex typedef {re, im} from shared package fft_pkg.
REQ-030 SHALL place the 4-entry show-ahead synchronous FIFO in sub-module mag_fifo.

Verification
REQ-031 SHALL cover: RAM preloaded with bin k = {k, 0}, out_ready=1, start -> 256 beats, out_mag=k^2, out_last on bin 255, done 1 cycle after.
REQ-032 SHALL cover: bin 3 = {16'h8000, 16'h8000} -> out_mag = 32'h8000_0000 (no overflow).
REQ-033 SHALL cover: out_ready toggled 1-of-3 cycles -> all 256 beats in order, stable while stalled, rd_addr pauses.
REQ-034 SHALL cover: start pulsed again at bin 100 -> ignored, frame completes with exactly 256 beats.
REQ-035 SHALL cover: reset at bin 50 -> out_valid=0 next cycle, no done; new start restarts from bin 0.
REQ-036 SHALL cover: FFT_MAG_BITREV_EN defined, N_LOG2=9 -> bin 1 reads rd_addr 256, bin 2 reads 128.
